imem_row_scheduler: RTL and testbench
=====================================

// Module: imem_row_scheduler
// PURPOSE
//  Clocked scheduler in front of the IFMAP row store. Sequences the row broadcast to PPE 5-9 at start of each timestep.
//  Round-robin arbitrates per-PPE "more inputs" requests and tracks each PPE's next-row pointer and current timestep.
//  Issues 1-cycle-latency row reads; emits one 33-bit router packet per read over a valid/ready channel.
// PARAMETERS
//  NUM_PPE     5   requesting PPEs; PPE p (0..4) has router ID PPE_BASE+p
//  PPE_BASE    5   router ID of PPE 0
//  IFMAP_SIZE  25  rows per timestep; also row width in bits
//  ROW_AW      5   row address width, >= clog2(IFMAP_SIZE)
// PORTS
//  clk          in   1    single clock
//  rst_n        in   1    asynchronous, active-low reset
//  ts_start     in   1    1-cycle pulse: weights loaded, begin timestep 1
//  ts_done      in   1    1-cycle pulse: timestep 1 done, begin timestep 2
//  req          in   5    1-cycle pulse per PPE: request next row
//  rd_en        out  1    row read strobe
//  rd_ts        out  1    0 = timestep-1 bank, 1 = timestep-2 bank
//  rd_row       out  5    row index read
//  rd_data      in   25   row bits, valid the cycle after rd_en
//  pkt_valid    out  1    packet valid
//  pkt_ready    in   1    router accepts when valid & ready
//  pkt_data     out  33   [32:29] dest, [28:25] opcode=OP_PPE_INPUT(1), [24:0] row
//  busy         out  1    state != IDLE or any pending
//  err          out  1    sticky: overrun or duplicate request
// BEHAVIOUR
//  Reset: clk/rst_n: one clock; reset is asynchronous and active-low. All outputs 0; state IDLE; ts=0; pending=0; ptr[p]=0; rr_last=4.
//  FSM: IDLE -> RD -> CAP -> SEND -> (RD | IDLE).
//   IDLE: bcast pending has priority: latch idx=0, mode=BC. Else any pend[]: latch RR winner, mode=RQ. Else stay.
//   RD: rd_en=1, rd_row = BC ? idx : ptr[idx], rd_ts = ts.
//   CAP: register pkt_data = {PPE_BASE+idx, 4'd1, rd_data}; pkt_valid=1 from next edge.
//   SEND: hold pkt_valid/pkt_data stable until pkt_ready.
//    On accept: BC & idx<4 -> idx++, RD. BC & idx==4 -> ptr[p]=p+1 for all p, clear bcast, IDLE.
//    RQ: ptr[idx]++, clear pend[idx], rr_last=idx, IDLE.
//  Latency: event sampled at edge E0 in IDLE -> pkt_valid high after E3; 1 packet per 4 cycles when ready=1.
//  ts_start sets ts=0, bcast pending; ts_done sets ts=1, bcast pending. Both take effect in IDLE only.
//  ts_start/ts_done while busy are held and serviced after the current packet.
//  Broadcast clears all pend[] and restarts pointers.
//  Round robin: search from rr_last+1 mod 5, wrapping; first set pend[] wins.
//  req[p] when pend[p] already set: err=1, request merged. Set and clear of pend[p] in the same cycle: set wins.
//  RQ with ptr[p] > IFMAP_SIZE-1: no read, no packet. Clear pend[p], err=1, IDLE.
//  Requests before first ts_start: err=1, dropped.
//  rst_n low mid-packet: immediate abort. pkt_valid drops asynchronously; no partial state survives.
// STRUCTURE
//  imem_pkg: OP_PPE_INPUT=1, OP_WEIGHTS_DONE=0, OP_TIMESTEP_DONE=15, PPE_BASE, packet field bit ranges, state enum.
//  Sub-module rr_arbiter5: pend[4:0], last[2:0] -> grant idx[2:0], any. Purely combinational.
//  Top keeps FSM, pointers, ts, pending regs and output registers.
// TESTING
//  1. Reset, ts_start pulse, pkt_ready=1 -> 5 packets, dest 5..9, rd_row 0..4, rd_ts=0, pkt_valid 3 cycles after pulse.
//  2. Then req=5'b00001 x3 with gaps -> dest 5, rows 1,2,3; ptr[0]=4.
//  3. req=5'b11111 in one cycle, rr_last=4 -> grant order 5,6,7,8,9. Repeat with rr_last=1 -> order 7,8,9,5,6.
//  4. pkt_ready=0 for 10 cycles in SEND -> pkt_data stable, no new rd_en. ts_done mid-wait -> after accept, rebroadcast rows 0..4 with rd_ts=1.
//  5. Drive PPE 4 until ptr=25 -> no packet, err=1. Duplicate req while pending -> err=1, single packet.
//  6. rst_n low during SEND -> pkt_valid=0 immediately. After release, req alone -> err=1, no packet until ts_start.

Source files
------------

// File: rtl/imem_row_scheduler_pkg.sv
// Shared constants, packet layout and state types for the IFMAP row scheduler.
package imem_row_scheduler_pkg;

  localparam int unsigned NUM_PPE    = 5;
  localparam int unsigned PPE_BASE   = 5;
  localparam int unsigned IFMAP_SIZE = 25;
  localparam int unsigned ROW_AW     = 5;

  localparam logic [3:0] OP_PPE_INPUT     = 4'd1;
  localparam logic [3:0] OP_WEIGHTS_DONE  = 4'd0;
  localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;

  // Router packet layout: {dest, opcode, row bits}
  localparam int unsigned PKT_W       = 33;
  localparam int unsigned PKT_DEST_HI = 32;
  localparam int unsigned PKT_DEST_LO = 29;
  localparam int unsigned PKT_OP_HI   = 28;
  localparam int unsigned PKT_OP_LO   = 25;
  localparam int unsigned PKT_ROW_HI  = 24;
  localparam int unsigned PKT_ROW_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_SEND
  } state_t;

  typedef enum logic {
    MODE_RQ,
    MODE_BC
  } mode_t;

  // Build the row packet destined for PPE index idx.
  function automatic logic [PKT_W-1:0] make_pkt(input logic [2:0]            idx,
                                                input logic [IFMAP_SIZE-1:0] row);
    logic [3:0] dest;
    dest = 4'(PPE_BASE) + {1'b0, idx};
    return {dest, OP_PPE_INPUT, row};
  endfunction

endpackage

// File: rtl/imem_row_scheduler_rr_arbiter5.sv
// Five-way round-robin arbiter: first set pend[] after last, wrapping.
module rr_arbiter5 (
  input  logic [4:0] pend,
  input  logic [2:0] last,
  output logic [2:0] idx,
  output logic       any
);

  int unsigned c;
  logic [2:0]  cand;

  // Scan the five candidates starting just after the previous winner.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    c    = 0;
    cand = '0;
    for (int unsigned k = 1; k <= 5; k++) begin
      c    = (32'(last) + k) % 5;
      cand = 3'(c);
      if (!any && pend[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_row_scheduler.sv
// Row scheduler in front of the IFMAP row store: broadcasts rows 0..4 to all
// PPEs at each timestep start and serves per-PPE next-row requests round robin.
module imem_row_scheduler
  import imem_row_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ts_start,
  input  logic                  ts_done,
  input  logic [NUM_PPE-1:0]    req,
  output logic                  rd_en,
  output logic                  rd_ts,
  output logic [ROW_AW-1:0]     rd_row,
  input  logic [IFMAP_SIZE-1:0] rd_data,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [PKT_W-1:0]      pkt_data,
  output logic                  busy,
  output logic                  err
);

  state_t              state;
  mode_t               mode;
  logic [2:0]          idx;
  logic                ts;
  logic                started;
  logic                bc_pend;
  logic                bc_ts;
  logic [NUM_PPE-1:0]  pend;
  logic [ROW_AW-1:0]   ptr [NUM_PPE];
  logic [2:0]          rr_last;
  logic [2:0]          gnt_idx;
  logic                gnt_any;

  rr_arbiter5 u_arb (
    .pend (pend),
    .last (rr_last),
    .idx  (gnt_idx),
    .any  (gnt_any)
  );

  // Busy while a transfer is in flight or any work is queued.
  assign busy = (state != ST_IDLE) || (|pend) || bc_pend;

  // Scheduler FSM with pending-event capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode      <= MODE_RQ;
      idx       <= '0;
      ts        <= 1'b0;
      started   <= 1'b0;
      bc_pend   <= 1'b0;
      bc_ts     <= 1'b0;
      pend      <= '0;
      rr_last   <= 3'd4;
      rd_en     <= 1'b0;
      rd_ts     <= 1'b0;
      rd_row    <= '0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      err       <= 1'b0;
      for (int unsigned p = 0; p < NUM_PPE; p++) ptr[p] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bc_pend) begin
            bc_pend <= 1'b0;
            ts      <= bc_ts;
            mode    <= MODE_BC;
            idx     <= '0;
            state   <= ST_RD;
            rd_en   <= 1'b1;
            rd_row  <= '0;
            rd_ts   <= bc_ts;
          end else if (gnt_any) begin
            if (ptr[gnt_idx] > ROW_AW'(IFMAP_SIZE - 1)) begin
              pend[gnt_idx] <= 1'b0;
              err           <= 1'b1;
            end else begin
              mode   <= MODE_RQ;
              idx    <= gnt_idx;
              state  <= ST_RD;
              rd_en  <= 1'b1;
              rd_row <= ptr[gnt_idx];
              rd_ts  <= ts;
            end
          end
        end
        ST_RD: begin
          rd_en <= 1'b0;
          state <= ST_CAP;
        end
        ST_CAP: begin
          pkt_data  <= make_pkt(idx, rd_data);
          pkt_valid <= 1'b1;
          state     <= ST_SEND;
        end
        ST_SEND: begin
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            if (mode == MODE_BC) begin
              if (idx < 3'd4) begin
                idx    <= idx + 3'd1;
                state  <= ST_RD;
                rd_en  <= 1'b1;
                rd_row <= ROW_AW'(idx + 3'd1);
                rd_ts  <= ts;
              end else begin
                for (int unsigned p = 0; p < NUM_PPE; p++) ptr[p] <= ROW_AW'(p + 1);
                pend  <= '0;
                state <= ST_IDLE;
              end
            end else begin
              ptr[idx]  <= ptr[idx] + ROW_AW'(1);
              pend[idx] <= 1'b0;
              rr_last   <= idx;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // New events are captured after the FSM clears so that a same-cycle
      // set overrides a clear (later non-blocking assignment wins).
      if (ts_done) begin
        bc_pend <= 1'b1;
        bc_ts   <= 1'b1;
      end else if (ts_start) begin
        bc_pend <= 1'b1;
        bc_ts   <= 1'b0;
      end
      if (ts_start) started <= 1'b1;

      for (int unsigned p = 0; p < NUM_PPE; p++) begin
        if (req[p]) begin
          if (!started) begin
            err <= 1'b1;
          end else begin
            if (pend[p]) err <= 1'b1;
            pend[p] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_row_scheduler.sv
// Directed self-checking bench for imem_row_scheduler.
module tb_imem_row_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ts_start = 1'b0;
  logic        ts_done = 1'b0;
  logic [4:0]  req = '0;
  logic        rd_en;
  logic        rd_ts;
  logic [4:0]  rd_row;
  logic [24:0] rd_data = '0;
  logic        pkt_valid;
  logic        pkt_ready = 1'b1;
  logic [32:0] pkt_data;
  logic        busy;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [32:0] pkt_q[$];
  logic [5:0]  rd_q[$];

  imem_row_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ts_start  (ts_start),
    .ts_done   (ts_done),
    .req       (req),
    .rd_en     (rd_en),
    .rd_ts     (rd_ts),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] mem_row(input logic ts, input logic [4:0] row);
    return {row, row, row, row, row} ^ (ts ? 25'h1F0F0F0 : 25'h00ACE1);
  endfunction

  function automatic logic [32:0] exp_pkt(input int dest, input logic ts, input int row);
    return {4'(dest), 4'd1, mem_row(ts, 5'(row))};
  endfunction

  // Row store model: one-cycle read latency, zero when not read.
  always @(posedge clk) rd_data <= rd_en ? mem_row(rd_ts, rd_row) : '0;

  // Record reads and accepted packets mid-cycle.
  always @(negedge clk) begin
    if (rd_en) rd_q.push_back({rd_ts, rd_row});
    if (pkt_valid && pkt_ready) pkt_q.push_back(pkt_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int t;
    t = 0;
    while (busy && t < budget) begin
      tick();
      t++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: busy got 1 expected 0 after %0d cycles", budget);
    end
    tick();
    tick();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int t;
    t = 0;
    while (!pkt_valid && t < budget) begin
      tick();
      t++;
    end
    check(name, pkt_valid, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    ts_start  = 1'b0;
    ts_done   = 1'b0;
    req       = '0;
    pkt_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_outputs", {rd_en, rd_ts, rd_row, pkt_valid, pkt_data, busy, err}, '0);
  endtask

  task automatic pulse_req(input logic [4:0] r);
    req = r;
    tick();
    req = '0;
  endtask

  task automatic pulse_start();
    ts_start = 1'b1;
    tick();
    ts_start = 1'b0;
  endtask

  task automatic check_bcast(input string name, input logic ts, input int first);
    check({name, "_count"}, pkt_q.size(), first + 5);
    for (int k = 0; k < 5; k++) begin
      if (first + k < pkt_q.size())
        check({name, "_pkt"}, pkt_q[first + k], exp_pkt(5 + k, ts, k));
      if (first + k < rd_q.size())
        check({name, "_rd"}, rd_q[first + k], {ts, 5'(k)});
    end
  endtask

  typedef struct packed {
    logic [4:0]  req;
    logic [2:0]  n;
    logic [19:0] dest;  // first packet in [19:16]
    logic [24:0] row;   // first packet in [24:20]
  } vec_t;

  function automatic vec_t mk(input logic [4:0] r, input logic [2:0] n,
                              input logic [19:0] d, input logic [24:0] rw);
    vec_t v;
    v.req  = r;
    v.n    = n;
    v.dest = d;
    v.row  = rw;
    return v;
  endfunction

  vec_t tbl[7];

  initial begin
    int edges;
    int unstable;
    int bad;
    logic [32:0] d0;

    // Pointers after broadcast are p+1, rr_last starts at 4.
    tbl[0] = mk(5'b00001, 3'd1, {4'd5, 16'd0}, {5'd1, 20'd0});
    tbl[1] = mk(5'b00001, 3'd1, {4'd5, 16'd0}, {5'd2, 20'd0});
    tbl[2] = mk(5'b00001, 3'd1, {4'd5, 16'd0}, {5'd3, 20'd0});
    tbl[3] = mk(5'b00010, 3'd1, {4'd6, 16'd0}, {5'd2, 20'd0});
    tbl[4] = mk(5'b11111, 3'd5, {4'd7, 4'd8, 4'd9, 4'd5, 4'd6},
                {5'd3, 5'd4, 5'd5, 5'd4, 5'd3});
    tbl[5] = mk(5'b10000, 3'd1, {4'd9, 16'd0}, {5'd6, 20'd0});
    tbl[6] = mk(5'b11111, 3'd5, {4'd5, 4'd6, 4'd7, 4'd8, 4'd9},
                {5'd5, 5'd4, 5'd4, 5'd5, 5'd7});

    // Test 1: broadcast after ts_start, latency counted in edges from E0.
    do_reset();
    pkt_q.delete();
    rd_q.delete();
    pulse_start();
    edges = 1;
    while (!pkt_valid && edges < 20) begin
      tick();
      edges++;
    end
    check("t1_latency_edges", edges, 4);
    wait_done(100);
    check_bcast("t1_bcast", 1'b0, 0);

    // Tests 2/3: request vectors applied from the table.
    for (int i = 0; i < 7; i++) begin
      pkt_q.delete();
      rd_q.delete();
      pulse_req(tbl[i].req);
      wait_done(200);
      check("vec_count", pkt_q.size(), tbl[i].n);
      for (int k = 0; k < int'(tbl[i].n); k++) begin
        if (k < pkt_q.size())
          check("vec_pkt", pkt_q[k],
                exp_pkt(int'(tbl[i].dest[19-4*k -: 4]), 1'b0, int'(tbl[i].row[24-5*k -: 5])));
        if (k < rd_q.size())
          check("vec_rd", rd_q[k], {1'b0, tbl[i].row[24-5*k -: 5]});
      end
    end
    check("vec_err", err, 1'b0);

    // Test 4: back-pressure in SEND, ts_done while waiting.
    pkt_q.delete();
    rd_q.delete();
    pkt_ready = 1'b0;
    pulse_req(5'b00001);
    wait_valid("t4_valid", 20);
    d0 = pkt_data;
    check("t4_first_pkt", d0, exp_pkt(5, 1'b0, 6));
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ts_done = (i == 4);
      if (!pkt_valid || pkt_data !== d0) unstable++;
    end
    ts_done = 1'b0;
    check("t4_stable", unstable, 0);
    check("t4_no_rd", rd_q.size(), 1);
    pkt_ready = 1'b1;
    wait_done(200);
    if (pkt_q.size() > 0) check("t4_held_pkt", pkt_q[0], d0);
    check_bcast("t4_rebcast", 1'b1, 1);

    // Test 5: walk PPE 4 to the end of the timestep, then overrun.
    bad = 0;
    for (int r = 5; r < 25; r++) begin
      pkt_q.delete();
      pulse_req(5'b10000);
      wait_done(50);
      if (pkt_q.size() != 1 || pkt_q[0] !== exp_pkt(9, 1'b1, r)) bad++;
    end
    check("t5_walk_bad", bad, 0);
    check("t5_err_before", err, 1'b0);
    pkt_q.delete();
    rd_q.delete();
    pulse_req(5'b10000);
    wait_done(50);
    repeat (5) tick();
    check("t5_overrun_pkts", pkt_q.size(), 0);
    check("t5_overrun_rd", rd_q.size(), 0);
    check("t5_overrun_err", err, 1'b1);

    // Test 5b: duplicate request while pending.
    do_reset();
    pkt_q.delete();
    rd_q.delete();
    pulse_start();
    wait_done(100);
    check_bcast("t5b_bcast", 1'b0, 0);
    check("t5b_err_clean", err, 1'b0);
    pkt_q.delete();
    pulse_req(5'b00100);
    pulse_req(5'b00100);
    wait_done(100);
    check("t5b_dup_count", pkt_q.size(), 1);
    if (pkt_q.size() > 0) check("t5b_dup_pkt", pkt_q[0], exp_pkt(7, 1'b0, 3));
    check("t5b_dup_err", err, 1'b1);

    // Test 6: reset mid-SEND, then requests before ts_start.
    do_reset();
    pkt_ready = 1'b0;
    pulse_start();
    wait_valid("t6_valid", 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", pkt_valid, 1'b0);
    check("t6_async_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    pkt_ready = 1'b1;
    tick();
    pkt_q.delete();
    rd_q.delete();
    pulse_req(5'b00001);
    repeat (20) tick();
    check("t6_early_pkts", pkt_q.size(), 0);
    check("t6_early_rd", rd_q.size(), 0);
    check("t6_early_err", err, 1'b1);
    pulse_start();
    wait_done(100);
    check_bcast("t6_bcast", 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
